buffer_scatter_decode: RTL and testbench
========================================

BUFFER_SCATTER_DECODE -- requirements
Module: buffer_scatter_decode

Interface
REQ-001 SHALL have no parameters; entry width is fixed at 8 bits and lane count at 16.
REQ-002 SHALL have port `clk`, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port `reset_n`, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port `in_valid`, input, 1 bit: packed buffer set offered.
REQ-005 SHALL have port `in_ready`, output, 1 bit: block can accept a packed set.
REQ-006 SHALL have port `in_data`, input, 128 bits: packed entries; entry k sits at bits [8k+7:8k].
REQ-007 SHALL have port `in_count`, input, 5 bits: number of valid packed entries, 0..31.
REQ-008 SHALL have port `in_lane_mask`, input, 16 bits: destination lane valids; bit i = lane i.
REQ-009 SHALL have port `out_valid`, output, 1 bit: scattered lane word available.
REQ-010 SHALL have port `out_ready`, input, 1 bit: consumer accepts the lane word.
REQ-011 SHALL have port `out_data`, output, 128 bits: lane i at bits [8i+7:8i].
REQ-012 SHALL have port `out_valids`, output, 16 bits: lanes actually written.
REQ-013 SHALL have port `err_overflow`, output, 1 bit: more packed entries than mask lanes.

Function
REQ-014 SHALL implement states IDLE, SCATTER and DONE.
REQ-015 SHALL perform an input handshake when `in_valid` and `in_ready` are both 1 at a rising edge.
REQ-016 SHALL drive `in_ready` as a registered 1 only while in IDLE.
REQ-017 On an input handshake, SHALL capture `in_data`, `in_lane_mask` and min(`in_count`,16); clear `out_data`, `out_valids`, `err_overflow` and index k; and enter SCATTER.
REQ-018 In each SCATTER cycle where the remaining mask is non-zero and k < count, SHALL take the lowest set bit of the remaining mask as a one-hot select for lane L.
REQ-019 In that same cycle, SHALL write entry k to lane L, set `out_valids`[L], clear bit L in the remaining mask, and increment k.
REQ-020 In a SCATTER cycle where the remaining mask is zero or k = count, SHALL enter DONE at the next edge.
REQ-021 On entering DONE, SHALL set `err_overflow` to 1 if and only if k < count.
REQ-022 SHALL raise `out_valid` exactly N+1 cycles after the input handshake, where N = min(count, popcount(mask)).
REQ-023 In DONE, SHALL hold `out_valid` at 1 and keep `out_data`, `out_valids` and `err_overflow` stable until `out_ready` is 1.
REQ-024 On the output handshake, SHALL deassert `out_valid` and return to IDLE, with `in_ready` rising at the same edge; data outputs hold until the next input handshake.
REQ-025 When count < popcount(mask), SHALL fill only the first count set lanes in ascending order and leave the remaining lanes out of `out_valids`; this is not an error.
REQ-026 SHALL treat count = 0 or mask = 0 as N = 0: `out_valid` one cycle after acceptance, `out_valids` = 0.
REQ-027 SHALL keep lanes not written at 8'h00 in `out_data`.
REQ-028 SHALL ignore `in_*` outside IDLE.
REQ-029 SHALL ignore `out_ready` outside DONE.

Reset
REQ-030 While `reset_n` = 0, SHALL hold state = IDLE and drive `in_ready`, `out_valid`, `out_data`, `out_valids`, `err_overflow` and k to 0.
REQ-031 SHALL drive `in_ready` to 1 at the first rising edge after `reset_n` deasserts.
REQ-032 SHALL abort any operation in progress on reset assertion, with no output handshake.

Verification
REQ-033 SHALL pass: mask=16'hFFFF, count=16, entries 8'h00..8'h0F -> `out_valid` 17 cycles after accept; lane i = i; `out_valids`=16'hFFFF; `err_overflow`=0.
REQ-034 SHALL pass: mask=16'h8421, count=4, entries A0,A1,A2,A3 -> lane0=A0, lane5=A1, lane10=A2, lane15=A3; others 00; `out_valid` after 5 cycles.
REQ-035 SHALL pass: mask=16'h00F0, count=2 -> `out_valids`=16'h0030; `err_overflow`=0; latency 3 cycles.
REQ-036 SHALL pass: mask=16'h0003, count=5 -> `out_valids`=16'h0003; `err_overflow`=1; latency 3 cycles.
REQ-037 SHALL pass: count=0, any mask -> `out_valids`=0 one cycle after accept; `out_ready` held 0 for 10 cycles -> outputs stable and `in_ready`=0 throughout.
REQ-038 SHALL pass: `reset_n` pulsed low mid-SCATTER -> all outputs 0 immediately; `in_ready`=1 one edge after release; a new set then completes normally.

Source files
------------

// File: rtl/buffer_scatter_decode.sv
// Scatters up to 16 packed 8-bit entries onto the set lanes of a 16-lane mask,
// one lane per cycle in ascending lane order, then holds the lane word until it is taken.
module buffer_scatter_decode (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [4:0]   in_count,
  input  logic [15:0]  in_lane_mask,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [15:0]  out_valids,
  output logic         err_overflow,
  output logic [1:0]   fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // the producer holds valid and payload until that edge, ready never waits on valid.
  typedef enum logic [1:0] {IDLE = 2'd0, SCATTER = 2'd1, DONE = 2'd2} state_t;

  state_t        state, next_state;
  logic [127:0]  data_q;
  logic [15:0]   mask_q;
  logic [4:0]    count_q;
  logic [4:0]    k_q;

  logic          in_fire;
  logic          step;
  logic [15:0]   sel;
  logic [7:0]    entry;
  logic [4:0]    count_clamped;

  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_fire)   next_state = SCATTER;
      SCATTER: if (!step)     next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  // sel is the lowest set bit of the remaining mask, i.e. the next destination lane.
  always_comb begin
    in_fire       = in_valid && in_ready && (state == IDLE);
    step          = (state == SCATTER) && (mask_q != 16'd0) && (k_q < count_q);
    sel           = step ? (mask_q & (~mask_q + 16'd1)) : 16'd0;
    entry         = data_q[{k_q[3:0], 3'b000} +: 8];
    count_clamped = (in_count > 5'd16) ? 5'd16 : in_count;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (next_state == IDLE);
      out_valid <= (next_state == DONE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q       <= '0;
      mask_q       <= '0;
      count_q      <= '0;
      k_q          <= '0;
      out_data     <= '0;
      out_valids   <= '0;
      err_overflow <= 1'b0;
    end else if (in_fire) begin
      data_q       <= in_data;
      mask_q       <= in_lane_mask;
      count_q      <= count_clamped;
      k_q          <= '0;
      out_data     <= '0;
      out_valids   <= '0;
      err_overflow <= 1'b0;
    end else if (step) begin
      for (int i = 0; i < 16; i++) begin
        if (sel[i]) out_data[8*i +: 8] <= entry;
      end
      out_valids <= out_valids | sel;
      mask_q     <= mask_q & ~sel;
      k_q        <= k_q + 5'd1;
    end else if (state == SCATTER) begin
      // Entries left over once the mask runs dry have no lane to go to.
      err_overflow <= (k_q < count_q);
    end
  end

endmodule

// File: tb/tb_buffer_scatter_decode.sv
// Directed bench for buffer_scatter_decode: hand-computed lane words, latencies and flags.
module tb_buffer_scatter_decode;

  logic         clk;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [4:0]   in_count;
  logic [15:0]  in_lane_mask;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [15:0]  out_valids;
  logic         err_overflow;
  logic [1:0]   fsm_state;

  int total;
  int bad;

  buffer_scatter_decode dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_count     (in_count),
    .in_lane_mask (in_lane_mask),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_valids   (out_valids),
    .err_overflow (err_overflow),
    .fsm_state    (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic send(input logic [127:0] d, input logic [4:0] c, input logic [15:0] m,
                      output int lat);
    int w;
    w = 0;
    while (in_ready !== 1'b1 && w < 50) begin
      @(posedge clk); #1; w++;
    end
    in_data = d; in_count = c; in_lane_mask = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({in_ready, out_valid, out_data, out_valids, err_overflow, fsm_state} !== '0) begin
      bad++;
      $display("FAIL reset_hold: got rdy=%b vld=%b data=%h valids=%h err=%b st=%0d want all 0",
               in_ready, out_valid, out_data, out_valids, err_overflow, fsm_state);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_full();
    logic [127:0] d;
    int lat;
    for (int k = 0; k < 16; k++) d[8*k +: 8] = 8'(k);
    send(d, 5'd16, 16'hFFFF, lat);
    total++;
    if (lat != 17) begin bad++; $display("FAIL full_latency: got %0d want 17", lat); end
    total++;
    if (out_data !== d) begin bad++; $display("FAIL full_data: got %h want %h", out_data, d); end
    total++;
    if (out_valids !== 16'hFFFF || err_overflow !== 1'b0) begin
      bad++; $display("FAIL full_flags: got valids=%h err=%b want ffff 0", out_valids, err_overflow);
    end
    total++;
    if (fsm_state !== 2'd2) begin bad++; $display("FAIL full_state: got %0d want 2", fsm_state); end
    drain();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== d) begin
      bad++; $display("FAIL full_drain: got vld=%b rdy=%b data=%h want 0 1 %h",
                      out_valid, in_ready, out_data, d);
    end
  endtask

  task automatic test_sparse();
    logic [127:0] d, exp;
    int lat;
    d = '0; exp = '0;
    d[7:0] = 8'hA0; d[15:8] = 8'hA1; d[23:16] = 8'hA2; d[31:24] = 8'hA3;
    d[39:32] = 8'h5C;  // beyond count, must not appear
    exp[7:0] = 8'hA0; exp[47:40] = 8'hA1; exp[87:80] = 8'hA2; exp[127:120] = 8'hA3;
    send(d, 5'd4, 16'h8421, lat);
    total++;
    if (lat != 5) begin bad++; $display("FAIL sparse_latency: got %0d want 5", lat); end
    total++;
    if (out_data !== exp) begin bad++; $display("FAIL sparse_data: got %h want %h", out_data, exp); end
    total++;
    if (out_valids !== 16'h8421 || err_overflow !== 1'b0) begin
      bad++; $display("FAIL sparse_flags: got valids=%h err=%b want 8421 0", out_valids, err_overflow);
    end
    drain();
  endtask

  task automatic test_partial();
    logic [127:0] exp;
    int lat;
    exp = '0; exp[39:32] = 8'h11; exp[47:40] = 8'h22;
    send(128'h66_55_44_33_22_11, 5'd2, 16'h00F0, lat);
    total++;
    if (lat != 3) begin bad++; $display("FAIL partial_latency: got %0d want 3", lat); end
    total++;
    if (out_valids !== 16'h0030 || err_overflow !== 1'b0 || out_data !== exp) begin
      bad++; $display("FAIL partial_result: got valids=%h err=%b data=%h want 0030 0 %h",
                      out_valids, err_overflow, out_data, exp);
    end
    drain();
  endtask

  task automatic test_overflow();
    int lat;
    send(128'h55_44_33_22_11, 5'd5, 16'h0003, lat);
    total++;
    if (lat != 3) begin bad++; $display("FAIL overflow_latency: got %0d want 3", lat); end
    total++;
    if (out_valids !== 16'h0003 || err_overflow !== 1'b1 || out_data !== 128'h2211) begin
      bad++; $display("FAIL overflow_result: got valids=%h err=%b data=%h want 0003 1 2211",
                      out_valids, err_overflow, out_data);
    end
    drain();
  endtask

  task automatic test_clamp();
    logic [127:0] d;
    int lat;
    for (int k = 0; k < 16; k++) d[8*k +: 8] = 8'(8'hF0 - k);
    send(d, 5'd31, 16'hFFFF, lat);
    total++;
    if (lat != 17) begin bad++; $display("FAIL clamp_latency: got %0d want 17", lat); end
    total++;
    if (out_valids !== 16'hFFFF || err_overflow !== 1'b0 || out_data !== d) begin
      bad++; $display("FAIL clamp_result: got valids=%h err=%b data=%h want ffff 0 %h",
                      out_valids, err_overflow, out_data, d);
    end
    drain();
  endtask

  task automatic test_zero_stall();
    int lat;
    send(128'hDEAD_BEEF, 5'd0, 16'hFFFF, lat);
    total++;
    if (lat != 1) begin bad++; $display("FAIL zero_latency: got %0d want 1", lat); end
    in_data = 128'h1234; in_count = 5'd3; in_lane_mask = 16'h0007; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== '0 ||
          out_valids !== 16'h0 || err_overflow !== 1'b0) begin
        bad++; $display("FAIL zero_stall_c%0d: got vld=%b rdy=%b data=%h valids=%h err=%b want 1 0 0 0 0",
                        c, out_valid, in_ready, out_data, out_valids, err_overflow);
      end
    end
    in_valid = 1'b0;
    drain();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL zero_drain: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] exp;
    int lat;
    in_data = 128'hFF_EE_DD_CC_BB_AA_99_88; in_count = 5'd8; in_lane_mask = 16'hFFFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, out_data, out_valids, err_overflow, fsm_state} !== '0) begin
      bad++; $display("FAIL midreset_clear: got rdy=%b vld=%b data=%h valids=%h err=%b st=%0d want all 0",
                      in_ready, out_valid, out_data, out_valids, err_overflow, fsm_state);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL midreset_release: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
    exp = '0; exp[7:0] = 8'h01; exp[47:40] = 8'h02; exp[87:80] = 8'h03; exp[127:120] = 8'h04;
    send(128'h04_03_02_01, 5'd4, 16'h8421, lat);
    total++;
    if (lat != 5 || out_data !== exp || out_valids !== 16'h8421 || err_overflow !== 1'b0) begin
      bad++; $display("FAIL midreset_recover: got lat=%0d data=%h valids=%h err=%b want 5 %h 8421 0",
                      lat, out_data, out_valids, err_overflow, exp);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int lat;
    send(128'h0B_0A, 5'd2, 16'h0101, lat);
    total++;
    if (lat != 3 || out_data !== 128'h0B_0000_0000_0000_000A) begin
      bad++; $display("FAIL b2b_first: got lat=%0d data=%h want 3 0b00000000000000000a", lat, out_data);
    end
    drain();
    send(128'h0C, 5'd1, 16'h0004, lat);
    total++;
    if (lat != 2 || out_data !== 128'h0C_0000 || out_valids !== 16'h0004) begin
      bad++; $display("FAIL b2b_second: got lat=%0d data=%h valids=%h want 2 0c0000 0004",
                      lat, out_data, out_valids);
    end
    drain();
  endtask

  initial begin
    total = 0; bad = 0;
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_count = '0;
    in_lane_mask = '0; out_ready = 1'b0;
    test_reset();
    test_full();
    test_sparse();
    test_partial();
    test_overflow();
    test_clamp();
    test_zero_stall();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
